// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one ALU between requesters
// A and B. The winning op and operands are latched and held on alu_*; after
// ALU_LAT cycles the result and flags are captured and returned on rsp_*,
// tagged with the id of the requester that issued them.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The requester keeps valid and payload steady until that edge and may drop
// valid beforehand. Ready never depends on the same port's payload. The
// response side holds rsp_valid, rsp_id, rsp_res and rsp_flags until
// rsp_ready is seen.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [3:0]       a_op,
    input  logic [WIDTH-1:0] a_lhs,
    input  logic [WIDTH-1:0] a_rhs,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [3:0]       b_op,
    input  logic [WIDTH-1:0] b_lhs,
    input  logic [WIDTH-1:0] b_rhs,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_lhs,
    output logic [WIDTH-1:0] alu_rhs,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [3:0]       alu_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Counter reload value; ALU_LAT is limited to 0..7.
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;   // 0 = A served last, 1 = B served last
    logic [2:0] lat_cnt;
    logic       grant_a;
    logic       grant_b;
    logic       accept;

    // Round-robin grant, only offered while idle; a tie goes to the port
    // that was not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == S_IDLE) begin
            if (a_req_valid && b_req_valid) begin
                grant_a = last_grant;
                grant_b = !last_grant;
            end else begin
                grant_a = a_req_valid;
                grant_b = b_req_valid;
            end
        end
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign accept      = grant_a || grant_b;
    assign rsp_valid   = (state == S_RESP);
    assign busy        = (state != S_IDLE);

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP when the
    // latency counter expires, RESP -> IDLE on the response handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)          state_nxt = S_EXEC;
            S_EXEC: if (lat_cnt == 3'd0) state_nxt = S_RESP;
            S_RESP: if (rsp_ready)       state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Operand latch, id/round-robin bookkeeping, latency count and result
    // capture. Operands are left in place after a response so alu_* keeps
    // showing the last issued op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op     <= '0;
            alu_lhs    <= '0;
            alu_rhs    <= '0;
            rsp_id     <= 1'b0;
            rsp_res    <= '0;
            rsp_flags  <= '0;
            last_grant <= 1'b1;
            lat_cnt    <= '0;
        end else if (accept) begin
            alu_op     <= grant_b ? b_op  : a_op;
            alu_lhs    <= grant_b ? b_lhs : a_lhs;
            alu_rhs    <= grant_b ? b_rhs : a_rhs;
            rsp_id     <= grant_b;
            last_grant <= grant_b;
            lat_cnt    <= LAT_INIT;
        end else if (state == S_EXEC) begin
            if (lat_cnt == 3'd0) begin
                rsp_res   <= alu_res;
                rsp_flags <= alu_flags;
            end else begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one ALU_LAT=1 instance carries the main
// sequence, ALU_LAT=0 and ALU_LAT=3 instances check response timing.
module tb_alu_arbiter;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main instance (ALU_LAT=1) ----------------
    logic         a_req_valid, a_req_ready, b_req_valid, b_req_ready;
    logic [3:0]   a_op, b_op, alu_op, alu_flags, rsp_flags;
    logic [W-1:0] a_lhs, a_rhs, b_lhs, b_rhs, alu_lhs, alu_rhs, alu_res, rsp_res;
    logic         rsp_valid, rsp_ready, rsp_id, busy;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_op(a_op), .a_lhs(a_lhs), .a_rhs(a_rhs),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_op(b_op), .b_lhs(b_lhs), .b_rhs(b_rhs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_res(alu_res), .alu_flags(alu_flags), .busy(busy)
    );

    // ---------------- latency instances (ALU_LAT=0 and 3), B port only ----------------
    logic         s_b_valid, s_rsp_ready, s_a_valid;
    logic [3:0]   s_b_op, s_a_op;
    logic [W-1:0] s_b_lhs, s_b_rhs, s_a_w;

    logic         z_a_ready, z_b_ready, z_rsp_valid, z_rsp_id, z_busy;
    logic [3:0]   z_rsp_flags, z_alu_op, z_alu_flags;
    logic [W-1:0] z_rsp_res, z_alu_lhs, z_alu_rhs, z_alu_res;

    logic         t_a_ready, t_b_ready, t_rsp_valid, t_rsp_id, t_busy;
    logic [3:0]   t_rsp_flags, t_alu_op, t_alu_flags;
    logic [W-1:0] t_rsp_res, t_alu_lhs, t_alu_rhs, t_alu_res;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(s_a_valid), .a_req_ready(z_a_ready),
        .a_op(s_a_op), .a_lhs(s_a_w), .a_rhs(s_a_w),
        .b_req_valid(s_b_valid), .b_req_ready(z_b_ready),
        .b_op(s_b_op), .b_lhs(s_b_lhs), .b_rhs(s_b_rhs),
        .rsp_valid(z_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(z_rsp_id),
        .rsp_res(z_rsp_res), .rsp_flags(z_rsp_flags),
        .alu_op(z_alu_op), .alu_lhs(z_alu_lhs), .alu_rhs(z_alu_rhs),
        .alu_res(z_alu_res), .alu_flags(z_alu_flags), .busy(z_busy)
    );

    alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(s_a_valid), .a_req_ready(t_a_ready),
        .a_op(s_a_op), .a_lhs(s_a_w), .a_rhs(s_a_w),
        .b_req_valid(s_b_valid), .b_req_ready(t_b_ready),
        .b_op(s_b_op), .b_lhs(s_b_lhs), .b_rhs(s_b_rhs),
        .rsp_valid(t_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(t_rsp_id),
        .rsp_res(t_rsp_res), .rsp_flags(t_rsp_flags),
        .alu_op(t_alu_op), .alu_lhs(t_alu_lhs), .alu_rhs(t_alu_rhs),
        .alu_res(t_alu_res), .alu_flags(t_alu_flags), .busy(t_busy)
    );

    // ---------------- ALU models ----------------
    // 0 add, 8 sub, 6 or, 7 and, anything else xor. Returns {ZF,SF,CF,OF,res}.
    function automatic logic [W+3:0] alu_f(input logic [3:0] op,
                                           input logic [W-1:0] l,
                                           input logic [W-1:0] r);
        logic [W:0]   wide;
        logic [W-1:0] s;
        logic         cf, of;
        wide = '0;
        cf   = 1'b0;
        of   = 1'b0;
        case (op)
            4'h0: begin
                wide = {1'b0, l} + {1'b0, r};
                s    = wide[W-1:0];
                cf   = wide[W];
                of   = (l[W-1] == r[W-1]) && (s[W-1] != l[W-1]);
            end
            4'h8: begin
                wide = {1'b0, l} - {1'b0, r};
                s    = wide[W-1:0];
                cf   = wide[W];
                of   = (l[W-1] != r[W-1]) && (s[W-1] != l[W-1]);
            end
            4'h6:    s = l | r;
            4'h7:    s = l & r;
            default: s = l ^ r;
        endcase
        return {(s == '0), s[W-1], cf, of, s};
    endfunction

    // One-stage pipelined ALU for the main instance.
    always @(posedge clk) {alu_flags, alu_res} <= alu_f(alu_op, alu_lhs, alu_rhs);

    // Purely combinational ALU for the ALU_LAT=0 instance.
    assign {z_alu_flags, z_alu_res} = alu_f(z_alu_op, z_alu_lhs, z_alu_rhs);

    // Three-stage pipelined ALU for the ALU_LAT=3 instance.
    logic [W+3:0] t_p1, t_p2, t_p3;
    always @(posedge clk) begin
        t_p1 <= alu_f(t_alu_op, t_alu_lhs, t_alu_rhs);
        t_p2 <= t_p1;
        t_p3 <= t_p2;
    end
    assign {t_alu_flags, t_alu_res} = t_p3;

    // ---------------- scoreboard ----------------
    logic [W+4:0] exp_q[$];   // {id, flags, res}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_rsp(input string tag);
        logic [W+4:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed a response slot, expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_id"},    64'(rsp_id),    64'(e[W+4]));
            check({tag, "_flags"}, 64'(rsp_flags), 64'(e[W+3:W]));
            check({tag, "_res"},   64'(rsp_res),   64'(e[W-1:0]));
        end
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_op = '0; a_lhs = '0; a_rhs = '0;
        b_req_valid = 1'b0; b_op = '0; b_lhs = '0; b_rhs = '0;
        rsp_ready = 1'b0;
        s_a_valid = 1'b0; s_a_op = '0; s_a_w = '0;
        s_b_valid = 1'b0; s_b_op = '0; s_b_lhs = '0; s_b_rhs = '0;
        s_rsp_ready = 1'b0;
        tick();
        tick();

        // reset values
        check("rst_busy",      64'(busy),        64'd0);
        check("rst_rsp_valid", 64'(rsp_valid),   64'd0);
        check("rst_a_ready",   64'(a_req_ready), 64'd0);
        check("rst_b_ready",   64'(b_req_ready), 64'd0);
        check("rst_alu_op",    64'(alu_op),      64'd0);
        check("rst_alu_lhs",   64'(alu_lhs),     64'd0);
        check("rst_rsp_res",   64'(rsp_res),     64'd0);
        check("rst_rsp_id",    64'(rsp_id),      64'd0);
        check("rst_rsp_flags", 64'(rsp_flags),   64'd0);
        check("rst_lat_busy",  64'({z_busy, t_busy}), 64'd0);

        // simultaneous A and B after reset: A wins the first tie
        rst_n = 1'b1;
        a_req_valid = 1'b1; a_op = 4'h7; a_lhs = 32'h0d000001; a_rhs = 32'h0f000001;
        b_req_valid = 1'b1; b_op = 4'h6; b_lhs = 32'h00000000; b_rhs = 32'h00000001;
        #1;
        check("tie_a_ready", 64'(a_req_ready), 64'd1);
        check("tie_b_ready", 64'(b_req_ready), 64'd0);
        tick();
        exp_q.push_back({1'b0, 4'h0, 32'h0d000001});
        check("tie_busy",    64'(busy),        64'd1);
        check("exec_ready",  64'({a_req_ready, b_req_ready}), 64'd0);
        check("tie_alu_op",  64'(alu_op),      64'h7);
        check("tie_alu_lhs", 64'(alu_lhs),     64'h0d000001);
        check("tie_alu_rhs", 64'(alu_rhs),     64'h0f000001);
        check("tie_k0_valid", 64'(rsp_valid),  64'd0);
        tick();
        check("tie_k1_valid", 64'(rsp_valid),  64'd0);
        tick();
        check_rsp("tie_a");

        // consumer stalls for 5 cycles: response held, no grants
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_res",   64'(rsp_res),   64'h0d000001);
            check("hold_id",    64'(rsp_id),    64'd0);
            check("hold_flags", 64'(rsp_flags), 64'h0);
            check("hold_ready", 64'({a_req_ready, b_req_ready}), 64'd0);
            check("hold_busy",  64'(busy),      64'd1);
        end
        rsp_handshake();
        check("post_hs_busy",  64'(busy),        64'd0);
        check("post_hs_valid", 64'(rsp_valid),   64'd0);
        check("alt_b_ready",   64'(b_req_ready), 64'd1);
        check("alt_a_ready",   64'(a_req_ready), 64'd0);
        tick();
        exp_q.push_back({1'b1, 4'h0, 32'h00000001});
        check("alt_b_alu_op", 64'(alu_op), 64'h6);
        tick();
        tick();
        check_rsp("tie_b");
        rsp_handshake();

        // both still valid: grant returns to A; unused op code passes through
        a_op = 4'hF; a_lhs = 32'h00000005; a_rhs = 32'h00000003;
        #1;
        check("alt_a2_ready", 64'(a_req_ready), 64'd1);
        check("alt_b2_ready", 64'(b_req_ready), 64'd0);
        tick();
        exp_q.push_back({1'b0, 4'h0, 32'h00000006});
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        check("opf_alu_op", 64'(alu_op), 64'hF);
        tick();
        tick();
        check_rsp("op_f");
        rsp_handshake();

        // A alone: add with carry-out to zero
        a_req_valid = 1'b1; a_op = 4'h0; a_lhs = 32'hffffffff; a_rhs = 32'h00000001;
        tick();
        exp_q.push_back({1'b0, 4'b1010, 32'h00000000});
        a_req_valid = 1'b0;
        tick();
        check("add_k1_valid", 64'(rsp_valid), 64'd0);
        tick();
        check_rsp("add_a");
        rsp_handshake();

        // rsp_ready while idle has no effect
        rsp_ready = 1'b1;
        tick();
        check("idle_rr_valid", 64'(rsp_valid), 64'd0);
        check("idle_rr_busy",  64'(busy),      64'd0);
        rsp_ready = 1'b0;

        // B alone: subtract with signed overflow
        b_req_valid = 1'b1; b_op = 4'h8; b_lhs = 32'h80000000; b_rhs = 32'h0fffffff;
        tick();
        exp_q.push_back({1'b1, 4'b0001, 32'h70000001});
        b_req_valid = 1'b0;
        tick();
        tick();
        check_rsp("sub_b");
        rsp_handshake();

        // A withdraws before acceptance while B waits: B granted, A never answered
        a_req_valid = 1'b1; a_op = 4'h0; a_lhs = 32'h1; a_rhs = 32'h1;
        b_req_valid = 1'b1; b_op = 4'h7; b_lhs = 32'hffff0000; b_rhs = 32'h00ff00ff;
        #1;
        check("wd_a_ready_pre", 64'(a_req_ready), 64'd1);
        a_req_valid = 1'b0;
        #1;
        check("wd_a_ready", 64'(a_req_ready), 64'd0);
        check("wd_b_ready", 64'(b_req_ready), 64'd1);
        tick();
        exp_q.push_back({1'b1, 4'h0, 32'h00ff0000});
        b_req_valid = 1'b0;
        tick();
        tick();
        check_rsp("withdraw_b");
        rsp_handshake();
        tick();
        tick();
        check("wd_idle_busy",  64'(busy),         64'd0);
        check("wd_idle_valid", 64'(rsp_valid),    64'd0);
        check("wd_no_a_rsp",   64'(exp_q.size()), 64'd0);

        // reset mid-EXEC drops the operation; pending A is taken afterwards
        a_req_valid = 1'b1; a_op = 4'h0; a_lhs = 32'h1; a_rhs = 32'h2;
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    64'(busy),        64'd0);
        check("mid_rst_valid",   64'(rsp_valid),   64'd0);
        check("mid_rst_alu_lhs", 64'(alu_lhs),     64'd0);
        check("mid_rst_a_ready", 64'(a_req_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back({1'b0, 4'h0, 32'h00000003});
        a_req_valid = 1'b0;
        check("post_rst_busy",    64'(busy),    64'd1);
        check("post_rst_alu_lhs", 64'(alu_lhs), 64'h1);
        check("post_rst_alu_rhs", 64'(alu_rhs), 64'h2);
        tick();
        tick();
        check_rsp("after_reset");
        rsp_handshake();

        // ALU_LAT=0 answers at accept+1, ALU_LAT=3 at accept+4
        s_b_valid = 1'b1; s_b_op = 4'h8; s_b_lhs = 32'h80000000; s_b_rhs = 32'h0fffffff;
        tick();
        s_b_valid = 1'b0;
        check("lat_k0_busy",   64'({z_busy, t_busy}),           64'h3);
        check("lat_k0_valid",  64'({z_rsp_valid, t_rsp_valid}), 64'h0);
        tick();
        check("lat0_valid",    64'(z_rsp_valid), 64'd1);
        check("lat0_res",      64'(z_rsp_res),   64'h70000001);
        check("lat0_flags",    64'(z_rsp_flags), 64'h1);
        check("lat0_id",       64'(z_rsp_id),    64'd1);
        check("lat3_k1_valid", 64'(t_rsp_valid), 64'd0);
        tick();
        check("lat3_k2_valid", 64'(t_rsp_valid), 64'd0);
        tick();
        check("lat3_k3_valid", 64'(t_rsp_valid), 64'd0);
        tick();
        check("lat3_valid",    64'(t_rsp_valid), 64'd1);
        check("lat3_res",      64'(t_rsp_res),   64'h70000001);
        check("lat3_flags",    64'(t_rsp_flags), 64'h1);
        check("lat3_id",       64'(t_rsp_id),    64'd1);
        s_rsp_ready = 1'b1;
        tick();
        s_rsp_ready = 1'b0;
        check("lat_done_busy", 64'({z_busy, t_busy}), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
